boron_key_rev: RTL and testbench
================================

BORON_KEY_REV -- requirements
Module: boron_key_rev

Interface
REQ-001 Parameter: ROUNDS, default 25, number of cipher rounds; ROUNDS+1 round keys (K0..K25) are produced.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level request; sampled only in IDLE.
REQ-005 master_key  input  80  cipher key; captured on the accepted start.
REQ-006 next  input  1  consumer acknowledge for the presented round key.
REQ-007 round_key  output  64  current round key, equal to K_i[63:0].
REQ-008 round_idx  output  5  index i of the presented key.
REQ-009 key_valid  output  1  round_key and round_idx are valid.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after K0 is accepted.

Function
REQ-012 The block feeds the decryption datapath with BORON-80 round keys in reverse order, K25 first and K0 last.
REQ-013 Forward update K_{i+1} = F(K_i, i+1), in this order: rotate the 80-bit register left by 13; replace bits [3:0] with S(bits [3:0]); XOR bits [63:59] with the 5-bit round constant.
REQ-014 S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}, indexed by input nibble 0..F.
REQ-015 Inverse step K_{i-1} = G(K_i, i), in this order: XOR bits [63:59] with i; replace bits [3:0] with S^-1(bits [3:0]); rotate right by 13.
REQ-016 FSM states: IDLE, FWD, REV, DONE.
REQ-017 IDLE: when start=1, load K0=master_key, clear the step counter, and go to FWD.
REQ-018 FWD: apply one F per cycle for exactly ROUNDS cycles (constant 1..25), then go to REV holding K25.
REQ-019 REV entry: key_valid=1, round_idx=25, round_key=K25[63:0]; latency from start sampled to first key_valid is ROUNDS+1 cycles.
REQ-020 REV, key_valid=1 and next=1 with round_idx>0: apply G, decrement round_idx, keep key_valid=1; the next key is visible the following cycle, so a key is accepted every cycle while next is held high.
REQ-021 REV, next=0: round_key, round_idx and key_valid hold unchanged.
REQ-022 REV, round_idx=0 and next=1: go to DONE with key_valid=0.
REQ-023 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-024 start is ignored in FWD, REV and DONE.
REQ-025 start held high re-triggers a new run from IDLE on the cycle after DONE.
REQ-026 next is ignored when key_valid=0.
REQ-027 All rotations are 80-bit circular; the round constant is 5 bits and never wraps within 1..25.
REQ-028 Outputs are registered; round_key has no combinational path from next.

Reset
REQ-029 rst=0 asynchronously forces: state=IDLE, key register=0, round_idx=0, key_valid=0, busy=0, done=0, round_key=0.
REQ-030 rst asserted mid-FWD or mid-REV aborts the run with no done pulse.
REQ-031 After rst rises, the block is in IDLE and accepts start on the first rising edge.

Verification
REQ-032 master_key=80'h0, start pulse, next=1 constantly: key_valid rises 26 cycles after start; 26 keys with round_idx 25..0; idx 1 key = 64'h080000000000000E; idx 0 key = 64'h0; done pulses once; then IDLE.
REQ-033 Random master_key with next=1 constantly: emitted keys match a reference model of F run forward and then reversed; idx 0 key = master_key[63:0]; no key skipped or repeated.
REQ-034 Random next stalls (about 50 percent duty): round_key and round_idx stay stable while next=0; the key sequence is identical to REQ-033.
REQ-035 start held high through a full run: done pulse, one IDLE cycle, new FWD run; start toggled during FWD and REV has no effect.
REQ-036 rst=0 at round_idx=12 in REV: all outputs are 0 immediately (asynchronously); no done pulse; a fresh start after release produces the correct full sequence.

Source files
------------

// File: rtl/boron_key_rev.sv
// boron_key_rev: BORON-80 round-key generator for the decryption path.
// Runs the forward key schedule to K_ROUNDS, then walks it back one key per
// accepted handshake, presenting K_ROUNDS first and K0 last.
module boron_key_rev #(
    parameter int unsigned ROUNDS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] master_key,
    input  logic        next,
    output logic [63:0] round_key,
    output logic [4:0]  round_idx,
    output logic        key_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned KEY_W = 80;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned RK_W  = 64;

    // S-box and its inverse, nibble 0 in the most significant position
    localparam logic [63:0] SBOX = 64'hE4B179CAD20F8536;
    localparam logic [63:0] SINV = 64'hA39E1DF4C572680B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W-1:0]   ctr_q, ctr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   ctr_inc;

    // Forward step: rotl 13, S-box low nibble, XOR round constant into [63:59]
    function automatic logic [KEY_W-1:0] f_step(input logic [KEY_W-1:0] k,
                                                input logic [IDX_W-1:0] rc);
        logic [KEY_W-1:0] t;
        t        = {k[66:0], k[79:67]};
        t[3:0]   = SBOX[4*(15-int'(t[3:0])) +: 4];
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    // Inverse step: XOR round constant, inverse S-box, rotr 13
    function automatic logic [KEY_W-1:0] g_step(input logic [KEY_W-1:0] k,
                                                input logic [IDX_W-1:0] rc);
        logic [KEY_W-1:0] t;
        t        = k;
        t[63:59] = t[63:59] ^ rc;
        t[3:0]   = SINV[4*(15-int'(t[3:0])) +: 4];
        return {t[12:0], t[79:13]};
    endfunction

    assign ctr_inc = ctr_q + IDX_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            ctr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = master_key;
                    ctr_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    state_d = FWD;
                end
            end
            FWD: begin
                // ROUNDS forward steps, then one cycle to present the last key
                if (ctr_q == IDX_W'(ROUNDS)) begin
                    valid_d = 1'b1;
                    idx_d   = IDX_W'(ROUNDS);
                    state_d = REV;
                end else begin
                    key_d = f_step(key_q, ctr_inc);
                    ctr_d = ctr_inc;
                end
            end
            REV: begin
                if (valid_q && next) begin
                    if (idx_q == '0) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        key_d = g_step(key_q, idx_q);
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign round_key = key_q[RK_W-1:0];
    assign round_idx = idx_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_boron_key_rev.sv
// tb_boron_key_rev: directed scenarios for the reverse key-schedule block.
module tb_boron_key_rev;

    localparam int unsigned ROUNDS = 25;
    localparam logic [63:0] SBOX   = 64'hE4B179CAD20F8536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        next = 1'b0;
    logic [79:0] master_key = '0;
    logic [63:0] round_key;
    logic [4:0]  round_idx;
    logic        key_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [79:0] exp_k [0:ROUNDS];
    logic [79:0] mk1, mk3;

    always #5 clk = ~clk;

    boron_key_rev #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .master_key (master_key),
        .next       (next),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .key_valid  (key_valid),
        .busy       (busy),
        .done       (done)
    );

    // Reference forward key step
    function automatic logic [79:0] f_model(input logic [79:0] k, input int rc);
        logic [79:0] t;
        t        = {k[66:0], k[79:67]};
        t[3:0]   = SBOX[4*(15-int'(t[3:0])) +: 4];
        t[63:59] = t[63:59] ^ 5'(rc);
        return t;
    endfunction

    task automatic build_model(input logic [79:0] mk);
        exp_k[0] = mk;
        for (int i = 1; i <= int'(ROUNDS); i++) exp_k[i] = f_model(exp_k[i-1], i);
    endtask

    task automatic pulse_start(input logic [79:0] mk);
        @(negedge clk);
        master_key = mk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        checks++;
        if ({round_key, round_idx} !== 69'd0) begin
            errors++;
            $display("FAIL reset_key: key=%h idx=%0d, required 0/0", round_key, round_idx);
        end
        checks++;
        if ({key_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: valid/busy/done=%b, required 000", {key_valid, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_key;
        int n, keys, dones, exp_idx;
        pulse_start(80'h0);
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 26) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles, required 26", n);
        end
        next = 1'b1;
        keys = 0;
        dones = 0;
        exp_idx = 25;
        for (int c = 0; c < 40; c++) begin
            if (key_valid === 1'b1) begin
                checks++;
                if (round_idx !== 5'(exp_idx)) begin
                    errors++;
                    $display("FAIL zero_idx: got %0d, required %0d", round_idx, exp_idx);
                end
                if (exp_idx == 2) begin
                    checks++;
                    if (round_key !== 64'h100000000001C00E) begin
                        errors++;
                        $display("FAIL zero_k2: got %h, required 100000000001c00e", round_key);
                    end
                end
                if (exp_idx == 1) begin
                    checks++;
                    if (round_key !== 64'h080000000000000E) begin
                        errors++;
                        $display("FAIL zero_k1: got %h, required 080000000000000e", round_key);
                    end
                end
                if (exp_idx == 0) begin
                    checks++;
                    if (round_key !== 64'h0) begin
                        errors++;
                        $display("FAIL zero_k0: got %h, required 0", round_key);
                    end
                end
                keys++;
                exp_idx--;
            end
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (keys != 26 || dones != 1) begin
            errors++;
            $display("FAIL zero_count: keys=%0d dones=%0d, required 26/1", keys, dones);
        end
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: busy=%b valid=%b, required 0/0", busy, key_valid);
        end
        next = 1'b0;
    endtask

    // Full run against the model; optional random next stalls
    task automatic test_sequence(input logic [79:0] mk, input bit stall, input string name);
        int n, keys, dones, exp_idx, cyc;
        bit hold;
        logic [63:0] pk;
        logic [4:0]  pi;
        build_model(mk);
        pulse_start(mk);
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 26) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required 26", name, n);
        end
        exp_idx = ROUNDS;
        keys = 0;
        dones = 0;
        cyc = 0;
        hold = 1'b0;
        pk = '0;
        pi = '0;
        while (dones == 0 && cyc < 400) begin
            if (key_valid === 1'b1) begin
                if (hold) begin
                    checks++;
                    if (round_key !== pk || round_idx !== pi) begin
                        errors++;
                        $display("FAIL %s_stall: key=%h idx=%0d, required %h/%0d", name, round_key, round_idx, pk, pi);
                    end
                end
                checks++;
                if (exp_idx < 0) begin
                    errors++;
                    $display("FAIL %s_extra: idx=%0d, required no further key", name, round_idx);
                end else if (round_idx !== 5'(exp_idx) || round_key !== exp_k[exp_idx][63:0]) begin
                    errors++;
                    $display("FAIL %s_key: key=%h idx=%0d, required %h/%0d", name, round_key, round_idx, exp_k[exp_idx][63:0], exp_idx);
                end
                if (exp_idx == 0) begin
                    checks++;
                    if (round_key !== mk[63:0]) begin
                        errors++;
                        $display("FAIL %s_k0: got %h, required %h", name, round_key, mk[63:0]);
                    end
                end
                next = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                hold = !next;
                pk = round_key;
                pi = round_idx;
                if (next) begin
                    exp_idx--;
                    keys++;
                end
            end else begin
                hold = 1'b0;
            end
            if (done === 1'b1) dones++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (keys != 26 || dones != 1) begin
            errors++;
            $display("FAIL %s_count: keys=%0d dones=%0d, required 26/1", name, keys, dones);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b done=%b, required 0/0", name, busy, done);
        end
        next = 1'b0;
    endtask

    task automatic test_start_held;
        int keys, dones, cyc, exp_idx;
        bit quiet;
        logic [79:0] mk2;
        @(negedge clk);
        master_key = 80'h0;
        start = 1'b1;
        next = 1'b1;
        keys = 0;
        dones = 0;
        cyc = 0;
        while (dones == 0 && cyc < 200) begin
            if (key_valid === 1'b1) keys++;
            if (done === 1'b1) dones++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (keys != 26 || dones != 1) begin
            errors++;
            $display("FAIL held_run1: keys=%0d dones=%0d, required 26/1", keys, dones);
        end
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_idle: busy=%b valid=%b, required 0/0", busy, key_valid);
        end
        mk2 = {16'($urandom), $urandom, $urandom};
        master_key = mk2;
        build_model(mk2);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_retrigger: busy=%b, required 1", busy);
        end
        keys = 0;
        dones = 0;
        cyc = 0;
        exp_idx = ROUNDS;
        quiet = 1'b0;
        while (dones == 0 && cyc < 200) begin
            if (key_valid === 1'b1) begin
                checks++;
                if (exp_idx < 0 || round_idx !== 5'(exp_idx) || round_key !== exp_k[(exp_idx < 0) ? 0 : exp_idx][63:0]) begin
                    errors++;
                    $display("FAIL held_key: key=%h idx=%0d, required idx %0d", round_key, round_idx, exp_idx);
                end
                if (exp_idx <= 2) quiet = 1'b1;
                exp_idx--;
                keys++;
            end
            if (done === 1'b1) dones++;
            start = quiet ? 1'b0 : 1'($urandom_range(0, 1));
            master_key = {16'($urandom), $urandom, $urandom};
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (keys != 26 || dones != 1) begin
            errors++;
            $display("FAIL held_run2: keys=%0d dones=%0d, required 26/1", keys, dones);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_stop: busy=%b, required 0", busy);
        end
        next = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_mid_reset(input logic [79:0] mk);
        int n, dones;
        build_model(mk);
        pulse_start(mk);
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        next = 1'b1;
        n = 0;
        while (round_idx !== 5'd12 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (round_idx !== 5'd12 || round_key !== exp_k[12][63:0] || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_k12: key=%h idx=%0d, required %h/12", round_key, round_idx, exp_k[12][63:0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({round_key, round_idx, key_valid, busy, done} !== 72'd0) begin
            errors++;
            $display("FAIL mid_async: key=%h idx=%0d v/b/d=%b, required all 0", round_key, round_idx, {key_valid, busy, done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_nodone: active cycles=%0d, required 0", dones);
        end
        next = 1'b0;
    endtask

    initial begin
        mk1 = {16'($urandom), $urandom, $urandom};
        mk3 = {16'($urandom), $urandom, $urandom};
        test_reset;
        test_zero_key;
        test_sequence(mk1, 1'b0, "rand");
        test_sequence(mk1, 1'b1, "stall");
        test_start_held;
        test_mid_reset(mk3);
        test_sequence(mk3, 1'b0, "after_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
